oled_spi_rx: RTL

- Receive-side model of the SSD1306-style OLED panel driven by the team's OLED controller.
- Samples the 4-wire write-only SPI stream (spi clk, data, dc_n) in the 100 MHz system domain and decodes command bytes into panel state registers.
- Writes data bytes into an external frame-buffer port using page/column addressing.
- Used as the far-end responder in system benches and as an on-chip capture/mirror of display contents.

---
 rtl/oled_spi_rx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/oled_spi_rx.sv
// oled_spi_rx: receive side of an SSD1306-style 4-wire SPI OLED link.
// Synchronizes the SPI pins into the system clock domain, assembles bytes,
// decodes commands into panel state and writes data bytes to a frame buffer.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   CMD   | idle; next dc_n=0 byte is an opcode
//   ARG1  | waiting for the first argument of the latched opcode
//   ARG2  | waiting for the second argument (0x21 / 0x22 only)
module oled_spi_rx #(
  parameter int PAGES   = 4,
  parameter int COLUMNS = 128,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 1000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              oled_spi_clk,
  input  logic              oled_spi_data,
  input  logic              oled_dc_n,
  input  logic              oled_reset_n,
  input  logic              oled_vdd,
  input  logic              oled_vbat,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              display_on,
  output logic              entire_on,
  output logic [7:0]        contrast,
  output logic              charge_pump_en,
  output logic              panel_lit,
  output logic              cmd_error
);

  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {CMD, ARG1, ARG2} decodeStateT;
  typedef enum logic {HORIZ, PAGE} addrModeT;

  logic [1:0] sclkSync, dataSync, dcSync;
  logic       sclkPrev;
  logic       spiEdge, gated;

  logic [7:0]    shiftReg, byteData;
  logic [2:0]    bitCnt;
  logic [TW-1:0] timeoutCnt;
  logic          byteValid, byteDc, timeoutErr;

  decodeStateT state, stateN;
  addrModeT    mode, modeN;
  logic [7:0]    opcode, opcodeN, contrastR, contrastN;
  logic [6:0]    col, colN, colStart, colStartN, colEnd, colEndN, arg1, arg1N;
  logic [PW-1:0] page, pageN, pageStart, pageStartN, pageEnd, pageEndN;
  logic          displayOnR, displayOnN, entireOnR, entireOnN, pumpR, pumpN;
  logic          doDecode, weN, decodeErr;

  // Two-flop synchronizers; the clock chain resets high so start-up sees no edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sclkSync <= 2'b11;
      sclkPrev <= 1'b1;
      dataSync <= 2'b00;
      dcSync   <= 2'b00;
    end else begin
      sclkSync <= {sclkSync[0], oled_spi_clk};
      sclkPrev <= sclkSync[1];
      dataSync <= {dataSync[0], oled_spi_data};
      dcSync   <= {dcSync[0], oled_dc_n};
    end
  end

  assign spiEdge = sclkSync[1] & ~sclkPrev;
  assign gated   = oled_vdd | ~oled_reset_n;

  // Bit assembly, byte completion and stalled-byte timeout.
  always_ff @(posedge clock) begin
    if (!reset_n || gated) begin
      shiftReg   <= '0;
      bitCnt     <= '0;
      timeoutCnt <= '0;
      byteValid  <= 1'b0;
      byteData   <= '0;
      byteDc     <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      byteValid  <= 1'b0;
      timeoutErr <= 1'b0;
      if (spiEdge) begin
        shiftReg   <= {shiftReg[6:0], dataSync[1]};
        bitCnt     <= bitCnt + 3'd1;
        timeoutCnt <= '0;
        if (bitCnt == 3'd7) begin
          byteValid <= 1'b1;
          byteData  <= {shiftReg[6:0], dataSync[1]};
          byteDc    <= dcSync[1];
        end
      end else if (bitCnt != 3'd0) begin
        if (timeoutCnt == TW'(TIMEOUT)) begin
          shiftReg   <= '0;
          bitCnt     <= '0;
          timeoutCnt <= '0;
          timeoutErr <= 1'b1;
        end else begin
          timeoutCnt <= timeoutCnt + TW'(1);
        end
      end
    end
  end

  // Decoder state register; panel reset returns all panel state to defaults.
  always_ff @(posedge clock) begin
    if (!reset_n || !oled_reset_n) begin
      state      <= CMD;
      mode       <= PAGE;
      opcode     <= '0;
      arg1       <= '0;
      col        <= '0;
      colStart   <= '0;
      colEnd     <= 7'(COLUMNS - 1);
      page       <= '0;
      pageStart  <= '0;
      pageEnd    <= PW'(PAGES - 1);
      contrastR  <= 8'h7F;
      displayOnR <= 1'b0;
      entireOnR  <= 1'b0;
      pumpR      <= 1'b0;
    end else begin
      state      <= stateN;
      mode       <= modeN;
      opcode     <= opcodeN;
      arg1       <= arg1N;
      col        <= colN;
      colStart   <= colStartN;
      colEnd     <= colEndN;
      page       <= pageN;
      pageStart  <= pageStartN;
      pageEnd    <= pageEndN;
      contrastR  <= contrastN;
      displayOnR <= displayOnN;
      entireOnR  <= entireOnN;
      pumpR      <= pumpN;
    end
  end

  assign doDecode = byteValid & ~gated;

  // Byte decode: command/argument handling, data writes and pointer advance.
  always_comb begin
    stateN     = state;
    modeN      = mode;
    opcodeN    = opcode;
    arg1N      = arg1;
    colN       = col;
    colStartN  = colStart;
    colEndN    = colEnd;
    pageN      = page;
    pageStartN = pageStart;
    pageEndN   = pageEnd;
    contrastN  = contrastR;
    displayOnN = displayOnR;
    entireOnN  = entireOnR;
    pumpN      = pumpR;
    weN        = 1'b0;
    decodeErr  = 1'b0;
    if (doDecode) begin
      if (byteDc) begin
        weN       = 1'b1;
        decodeErr = (state != CMD);
        stateN    = CMD;
        if (mode == PAGE) begin
          colN = (col == 7'(COLUMNS - 1)) ? 7'd0 : col + 7'd1;
        end else if (col != colEnd) begin
          colN = col + 7'd1;
        end else begin
          colN  = colStart;
          pageN = (page == pageEnd) ? pageStart : page + PW'(1);
        end
      end else begin
        case (state)
          CMD: begin
            casez (byteData)
              8'hAE, 8'hAF: displayOnN = byteData[0];
              8'hA4, 8'hA5: entireOnN  = byteData[0];
              8'hA0, 8'hA1, 8'hC0, 8'hC8: ;
              8'h0?: colN = {col[6:4], byteData[3:0]};
              8'h1?: colN = {byteData[2:0], col[3:0]};
              8'b1011_0???: pageN = byteData[PW-1:0];
              8'h81, 8'h8D, 8'hD9, 8'hDA, 8'h20, 8'h21, 8'h22: begin
                opcodeN = byteData;
                stateN  = ARG1;
              end
              default: decodeErr = 1'b1;
            endcase
          end
          ARG1: begin
            stateN = CMD;
            case (opcode)
              8'h81: contrastN = byteData;
              8'h8D: pumpN     = byteData[2];
              8'h20: modeN     = byteData[1] ? PAGE : HORIZ;
              8'h21, 8'h22: begin
                arg1N  = byteData[6:0];
                stateN = ARG2;
              end
              default: ;
            endcase
          end
          default: begin
            stateN = CMD;
            if (opcode == 8'h21) begin
              colStartN = arg1;
              colN      = arg1;
              colEndN   = byteData[6:0];
            end else begin
              pageStartN = arg1[PW-1:0];
              pageN      = arg1[PW-1:0];
              pageEndN   = byteData[PW-1:0];
            end
          end
        endcase
      end
    end
  end

  assign fb_we          = weN;
  assign fb_addr        = ADDR_W'(page) * ADDR_W'(COLUMNS) + ADDR_W'(col);
  assign fb_wdata       = byteData;
  assign display_on     = displayOnR;
  assign entire_on      = entireOnR;
  assign contrast       = contrastR;
  assign charge_pump_en = pumpR;
  assign panel_lit      = displayOnR & pumpR & ~oled_vbat & ~oled_vdd;
  assign cmd_error      = decodeErr | timeoutErr;

endmodule
